// File: rtl/maj_pkg.sv
// maj_pkg: shared types and default sizing for the majority sequencer.
//   maj_state_t : controller state encoding
//   MAJ_N       : default elements per frame
//   MAJ_W       : default element width in bits
package maj_pkg;

  localparam int MAJ_N = 13;
  localparam int MAJ_W = 4;

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_VOTE  = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } maj_state_t;

endpackage

// File: rtl/maj_buffer.sv
// maj_buffer: N x W element store for one majority frame.
// Ports:
//   clk     : write clock
//   we      : write enable, stores data at idx on the rising edge
//   idx     : shared write/read index
//   data    : write data
//   rd_data : asynchronous read of element idx
// Contents are intentionally not reset; the controller never reads an
// element before writing it in the current frame.
module maj_buffer
  import maj_pkg::*;
#(
  parameter int N  = MAJ_N,
  parameter int W  = MAJ_W,
  parameter int IW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] idx,
  input  logic [W-1:0]  data,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem [N];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= data;
  end

  assign rd_data = mem[idx];

endmodule

// File: rtl/majority_seq_ctrl.sv
// majority_seq_ctrl: loads a frame of N elements, runs a Boyer-Moore vote
// pass and a verification count pass, then presents the majority result.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   clear               : synchronous frame abort (highest priority)
//   in_valid/in_ready   : element input handshake, in_data is the element
//   out_valid/out_ready : result handshake
//   maj_found           : some value occurs more than N/2 times
//   maj_value           : majority value, 0 when none
//   maj_count           : occurrence count of the candidate in DONE
//                         (present only when MAJ_COUNT_OUT_EN is defined)
//
// state | meaning
// LOAD  | accepting elements into the buffer, idx = write position
// VOTE  | Boyer-Moore pass, one element per cycle
// CHECK | counting occurrences of the candidate
// DONE  | result valid, waiting for out_ready
module majority_seq_ctrl
  import maj_pkg::*;
#(
  parameter int N = MAJ_N,
  parameter int W = MAJ_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       in_valid,
  input  logic [W-1:0]               in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       maj_found,
  output logic [W-1:0]               maj_value
`ifdef MAJ_COUNT_OUT_EN
  ,
  output logic [$clog2(N+1)-1:0]     maj_count
`endif
);

  localparam int IW = $clog2(N + 1);

  maj_state_t    state, state_n;
  logic [IW-1:0] idx, idx_n;
  logic [IW-1:0] cnt, cnt_n;
  logic [IW-1:0] occ, occ_n;
  logic [W-1:0]  cand, cand_n;
  logic [W-1:0]  rd_data;
  logic          we;
  logic          last;

  maj_buffer #(.N(N), .W(W), .IW(IW)) u_buf (
    .clk     (clk),
    .we      (we),
    .idx     (idx),
    .data    (in_data),
    .rd_data (rd_data)
  );

  assign last = (idx == IW'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_LOAD;
      idx   <= '0;
      cnt   <= '0;
      occ   <= '0;
      cand  <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      cnt   <= cnt_n;
      occ   <= occ_n;
      cand  <= cand_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    occ_n   = occ;
    cand_n  = cand;
    we      = 1'b0;
    case (state)
      S_LOAD: begin
        if (in_valid) begin
          we = 1'b1;
          if (last) begin
            state_n = S_VOTE;
            idx_n   = '0;
            cnt_n   = '0;
          end else begin
            idx_n = idx + 1'b1;
          end
        end
      end
      S_VOTE: begin
        if (cnt == '0) begin
          cand_n = rd_data;
          cnt_n  = IW'(1);
        end else if (rd_data == cand) begin
          cnt_n = cnt + 1'b1;
        end else begin
          cnt_n = cnt - 1'b1;
        end
        if (last) begin
          state_n = S_CHECK;
          idx_n   = '0;
          occ_n   = '0;
        end else begin
          idx_n = idx + 1'b1;
        end
      end
      S_CHECK: begin
        if (rd_data == cand) occ_n = occ + 1'b1;
        if (last) begin
          state_n = S_DONE;
          idx_n   = '0;
        end else begin
          idx_n = idx + 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_n = S_LOAD;
          idx_n   = '0;
        end
      end
      default: state_n = S_LOAD;
    endcase
    // Abort overrides any accept or result handshake in the same cycle.
    if (clear) begin
      state_n = S_LOAD;
      idx_n   = '0;
      cnt_n   = '0;
      occ_n   = '0;
      cand_n  = '0;
      we      = 1'b0;
    end
  end

  assign in_ready  = (state == S_LOAD);
  assign out_valid = (state == S_DONE);
  // 2*occ > N, evaluated one bit wider so the doubling cannot overflow.
  assign maj_found = out_valid && ({occ, 1'b0} > (IW + 1)'(N));
  assign maj_value = maj_found ? cand : '0;

`ifdef MAJ_COUNT_OUT_EN
  assign maj_count = out_valid ? occ : '0;
`endif

endmodule

// File: doc/majority_seq_ctrl.md
MAJORITY_SEQ_CTRL -- requirements
Module: majority_seq_ctrl

Interface
REQ-001 Parameter N, default 13: number of elements per majority frame (N >= 1).
REQ-002 Parameter W, default 4: element width in bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 clear  input  1  synchronous frame abort; returns the block to LOAD.
REQ-006 in_valid  input  1  in_data holds a valid element.
REQ-007 in_data  input  W  element value.
REQ-008 in_ready  output  1  block accepts an element this cycle.
REQ-009 out_valid  output  1  result is valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 maj_found  output  1  some value occurs more than N/2 times in the frame.
REQ-012 maj_value  output  W  majority value; 0 when maj_found=0.

Function
REQ-013 FSM states SHALL be LOAD, VOTE, CHECK, DONE.
REQ-014 LOAD: in_ready=1; on in_valid&in_ready, element stored at buf[idx] and idx increments; the N-th accept moves to VOTE with idx=0.
REQ-015 VOTE (Boyer-Moore pass, one element per cycle): cnt==0 -> cand=buf[idx], cnt=1; buf[idx]==cand -> cnt+1; else cnt-1; after idx=N-1 move to CHECK with idx=0, occ=0.
REQ-016 CHECK: occ increments when buf[idx]==cand; after idx=N-1 move to DONE.
REQ-017 DONE: out_valid=1; maj_found=1 iff 2*occ > N; maj_value=cand if found else 0.
REQ-018 outputs SHALL stay stable while out_valid=1 and out_ready=0.
REQ-019 out_valid&out_ready SHALL move to LOAD with idx=0 on the same edge.
REQ-020 out_valid SHALL rise exactly 2N clock edges after the edge accepting the N-th element (26 for N=13).
REQ-021 in_ready=0 in VOTE, CHECK, DONE; in_valid there is ignored.
REQ-022 cnt, occ, idx width SHALL be $clog2(N+1); no wrap is possible by construction.
REQ-023 clear SHALL take priority over every other event, including a simultaneous accept or output handshake; the next state is LOAD, idx=0, out_valid=0.

Reset
REQ-024 rst_n=0 SHALL immediately force state=LOAD, idx=cnt=occ=0, cand=0, out_valid=0, maj_found=0, maj_value=0, in_ready=1.
REQ-025 reset mid-frame SHALL discard all buffered elements; buf contents need not be reset.

Configuration
REQ-026 macro MAJ_COUNT_OUT_EN defined: extra output maj_count [$clog2(N+1)-1:0] equals occ in DONE, 0 otherwise, reset 0.
REQ-027 macro absent: port maj_count and its logic do not exist; all other behaviour is identical.

Structure
REQ-028 package maj_pkg SHALL hold the state enum type maj_state_t and the default constants MAJ_N=13 and MAJ_W=4.
REQ-029 the N x W element store SHALL be sub-module maj_buffer (write port idx/data/we, one asynchronous read port); the FSM and counters live in majority_seq_ctrl.

Verification
REQ-030 frame 3,2,6,2,8,13,8,5,11,12,15,7,12 -> out_valid after 26 edges, maj_found=0, maj_value=0.
REQ-031 frame 2,2,1,2,8,2,8,2,11,2,15,2,12 (seven 2s) -> maj_found=1, maj_value=2; with MAJ_COUNT_OUT_EN, maj_count=7.
REQ-032 frame with six 9s and seven distinct others -> maj_found=0; Boyer-Moore candidate is rejected by CHECK.
REQ-033 hold out_ready=0 for 5 cycles in DONE -> outputs stable and in_ready=0; then out_ready=1 -> LOAD next edge; a second frame of all 7s gives found=1, value=7.
REQ-034 assert clear during CHECK, and separately on the edge of the 13th accept -> LOAD, idx=0; a following full frame produces a correct result.
REQ-035 rst_n low mid-VOTE for 1 ns asynchronously -> outputs at reset values before the next edge; a following frame is processed correctly.
